// File: rtl/sd_cmd_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module   : sd_cmd_frame_tx
//  Purpose  : Host-side SD command-line transmitter. Builds the 48-bit command
//             frame {start 0, transmission 1, index[5:0], argument[31:0],
//             CRC7, end 1} and serialises it MSb first onto the CMD line, one
//             bit per clk_i cycle. The CRC7 bits come from an external serial
//             CRC7 generator: this block feeds it the 40 header/argument bits,
//             then asks it to shift its remainder out and splices that stream
//             into the frame.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    PREAMBLE_CYCLES  cycles CMD is driven high before the start bit (0..15)
//  Ports
//    clk_i            SD-domain clock, one frame bit per cycle
//    rst_ni           asynchronous reset, active low (shared with CRC7 gen)
//    start_i          frame request, accepted only while ready_o=1
//    cmd_index_i      6-bit command index, sampled at accept
//    cmd_argument_i   32-bit command argument, sampled at accept
//    ready_o          high only while idle
//    done_o           one-cycle pulse coincident with the end bit on cmd_o
//    crc_dat_ser_o    serial data to the CRC7 generator
//    crc_shift_out_o  shift-out control to the CRC7 generator
//    crc_ser_i        serial CRC output from the CRC7 generator
//    cmd_o            registered CMD line value
//    cmd_en_o         registered CMD pad output enable
// ============================================================================
module sd_cmd_frame_tx #(
    parameter int unsigned PREAMBLE_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [5:0]  cmd_index_i,
    input  logic [31:0] cmd_argument_i,
    output logic        ready_o,
    output logic        done_o,
    output logic        crc_dat_ser_o,
    output logic        crc_shift_out_o,
    input  logic        crc_ser_i,
    output logic        cmd_o,
    output logic        cmd_en_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_DATA = 3'd2,
        ST_CRC  = 3'd3,
        ST_END  = 3'd4
    } state_t;

    localparam logic [5:0] PRE_LAST  = (PREAMBLE_CYCLES == 0) ? 6'd0
                                                             : 6'(PREAMBLE_CYCLES - 1);
    localparam logic [5:0] DATA_LAST = 6'd39;
    localparam logic [5:0] CRC_LAST  = 6'd6;

    state_t      state;
    state_t      state_next;
    logic [5:0]  bit_cnt;
    logic [39:0] shift_reg;
    logic        frame_bit;
    logic        accept;

    assign accept = (state == ST_IDLE) && start_i;

    // ------------------------------------------------------------------------
    // Next-state and combinational outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_next      = state;
        frame_bit       = 1'b1;
        crc_dat_ser_o   = 1'b0;
        crc_shift_out_o = 1'b0;
        ready_o         = 1'b0;

        case (state)
            ST_IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    state_next = (PREAMBLE_CYCLES == 0) ? ST_DATA : ST_PRE;
                end
            end
            ST_PRE: begin
                // CRC inputs stay low so the generator remains at zero
                if (bit_cnt == PRE_LAST) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                frame_bit     = shift_reg[39];
                crc_dat_ser_o = shift_reg[39];
                if (bit_cnt == DATA_LAST) begin
                    state_next = ST_CRC;
                end
            end
            ST_CRC: begin
                // Generator shifts its remainder out MSb first; after seven
                // shifts it has cleared itself for the next frame.
                crc_shift_out_o = 1'b1;
                frame_bit       = crc_ser_i;
                if (bit_cnt == CRC_LAST) begin
                    state_next = ST_END;
                end
            end
            ST_END: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Bit counter and frame shift register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt   <= 6'd0;
            shift_reg <= 40'd0;
        end else begin
            if ((state == ST_IDLE) || (state_next != state)) begin
                bit_cnt <= 6'd0;
            end else begin
                bit_cnt <= bit_cnt + 6'd1;
            end

            if (accept) begin
                shift_reg <= {1'b0, 1'b1, cmd_index_i, cmd_argument_i};
            end else if (state == ST_DATA) begin
                shift_reg <= {shift_reg[38:0], 1'b0};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pad output register (everything on the pad lags the state by a cycle)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_o    <= 1'b1;
            cmd_en_o <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            cmd_o  <= frame_bit;
            done_o <= (state == ST_END);
            // A frame accepted in the cycle right after END keeps the pad
            // enabled: the idle-high bit becomes an extra preamble bit, so
            // back-to-back frames leave no undriven gap on CMD.
            cmd_en_o <= (state != ST_IDLE) || (accept && cmd_en_o);
        end
    end

endmodule
`default_nettype wire
